// File: rtl/adder4.sv
// Registered WIDTH-bit ripple-carry adder: {cout,S} = A + B + cin, plus signed overflow.
// One full-adder instance per bit; results land in output registers one cycle after capture.

module adder4_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

module adder4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);
  localparam int STAGES = 1;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
  } res_t;

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;
  res_t             core;
  res_t             res_q;
  logic             vld_q;
  logic [STAGES:0]  vld_pipe;

  assign c[0] = cin;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      adder4_fa u_fa (
        .a  (A[i]),
        .b  (B[i]),
        .ci (c[i]),
        .s  (sum[i]),
        .co (c[i+1])
      );
    end
  endgenerate

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  always_comb begin
    core      = '0;
    core.s    = sum;
    core.cout = c[WIDTH];
    core.ovf  = c[WIDTH] ^ c[WIDTH-1];
  end

  // Results only load on a valid beat, so garbage on idle inputs never reaches S/cout/ovf.
  always_ff @(posedge clk) begin
    if (rst)           res_q <= '0;
    else if (in_valid) res_q <= core;
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= 1'b0;
    else     vld_q <= vld_pipe[0];
  end

  assign vld_pipe  = {vld_q, in_valid};

  assign S         = res_q.s;
  assign cout      = res_q.cout;
  assign ovf       = res_q.ovf;
  assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_adder4.sv
// Self-checking bench for adder4: cycle-by-cycle reference model plus directed literal checks.

module tb_adder4;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic       cin = 1'b0;
  logic [3:0] S;
  logic       cout;
  logic       ovf;
  logic       out_valid;

  int vectors = 0;
  int errors  = 0;

  adder4 #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .S         (S),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Reference: {ovf, cout, S} from plain integer arithmetic.
  function automatic logic [5:0] ref_add(input logic [3:0] a, input logic [3:0] b, input logic c);
    int u;
    int sa;
    int sb;
    int sg;
    logic o;
    u  = int'(a) + int'(b) + int'(c);
    sa = $signed(a);
    sb = $signed(b);
    sg = sa + sb + int'(c);
    o  = (sg > 7) || (sg < -8);
    return {o, u[4], u[3:0]};
  endfunction

  // Model state, updated at each rising edge from the sampled inputs.
  logic [3:0] m_s = '0;
  logic       m_c = 1'b0;
  logic       m_o = 1'b0;
  logic       m_v = 1'b0;
  logic       mdl_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_s    <= '0;
      m_c    <= 1'b0;
      m_o    <= 1'b0;
      m_v    <= 1'b0;
      mdl_ok <= 1'b1;
    end else begin
      m_v <= in_valid;
      if (in_valid) {m_o, m_c, m_s} <= ref_add(A, B, cin);
    end
  end

  always @(negedge clk) begin
    if (mdl_ok) begin
      vectors++;
      if ({S, cout, ovf, out_valid} !== {m_s, m_c, m_o, m_v}) begin
        errors++;
        $display("FAIL model: got S=%h cout=%b ovf=%b ov=%b, want S=%h cout=%b ovf=%b ov=%b at %0t",
                 S, cout, ovf, out_valid, m_s, m_c, m_o, m_v, $time);
      end
    end
  end

  task automatic step(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b, input logic c);
    rst = r; in_valid = v; A = a; B = b; cin = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] es, input logic ec, input logic eo, input logic ev);
    vectors++;
    if ({S, cout, ovf, out_valid} !== {es, ec, eo, ev}) begin
      errors++;
      $display("FAIL %s: got S=%b cout=%b ovf=%b ov=%b, want S=%b cout=%b ovf=%b ov=%b",
               name, S, cout, ovf, out_valid, es, ec, eo, ev);
    end
  endtask

  logic [3:0] ta [7] = '{4'h0, 4'h1, 4'h3, 4'h5, 4'hF, 4'hA, 4'hF};
  logic [3:0] tb [7] = '{4'h0, 4'h2, 4'h3, 4'h5, 4'h1, 4'h5, 4'hF};
  logic       tc [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [3:0] es [7] = '{4'b0000, 4'b0011, 4'b0111, 4'b1010, 4'b0001, 4'b1111, 4'b1111};
  logic       ec [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic       eo [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    // Reset held two cycles with live-looking operands
    step(1'b1, 1'b1, 4'hF, 4'hF, 1'b1);
    chk("reset1", 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'hF, 4'hF, 1'b1);
    chk("reset2", 4'h0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, ta[i], tb[i], tc[i]);
      chk($sformatf("sweep%0d", i), es[i], ec[i], eo[i], 1'b1);
    end

    // Hold after F+1+1
    step(1'b0, 1'b1, 4'hF, 4'h1, 1'b1);
    chk("hold_load", 4'b0001, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'h7, 4'h7, 1'b0);
    chk("hold1", 4'b0001, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'h9, 4'h6, 1'b1);
    chk("hold2", 4'b0001, 1'b1, 1'b0, 1'b0);

    // Reset mid-stream
    step(1'b0, 1'b1, 4'h2, 4'h3, 1'b0);
    chk("stream", 4'b0101, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 4'h3, 4'h3, 1'b0);
    chk("midreset", 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'h1, 4'h2, 1'b0);
    chk("after_reset", 4'b0011, 1'b0, 1'b0, 1'b1);

    // Exhaustive back-to-back sweep, checked by the model process
    for (int i = 0; i < 512; i++) begin
      logic [8:0] k;
      k = 9'(i);
      step(1'b0, 1'b1, k[8:5], k[4:1], k[0]);
    end

    // Random traffic with idle gaps and occasional reset
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom), 4'($urandom), 1'($urandom));
    end

    step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
